lcd_scanout: RTL and testbench

// - Read-side counterpart of the LCD controller's write path: walks the 96x64 visible LCD RAM

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_scanout_if.sv | 28 ++
 rtl/lcd_timing_gen.sv | 54 +++++
 rtl/lcd_scanout.sv | 123 ++++++++++++
 tb/tb_lcd_scanout.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD read-back scanout path.
// Geometry: 96x64 visible inside a 128x80 raster; syncs at dot 104 (8 dots) and line 68 (2 lines).
package lcd_pkg;

    localparam int unsigned LCD_WIDTH  = 96;
    localparam int unsigned LCD_HEIGHT = 64;
    localparam int unsigned LCD_PAGES  = 8;

    localparam logic [6:0] H_ACTIVE    = 7'(LCD_WIDTH);
    localparam logic [6:0] V_ACTIVE    = 7'(LCD_HEIGHT);
    localparam logic [6:0] H_LAST      = 7'd127;
    localparam logic [6:0] V_LAST      = 7'd79;
    localparam logic [6:0] HSYNC_START = 7'd104;
    localparam logic [6:0] HSYNC_END   = 7'd112;
    localparam logic [6:0] VSYNC_START = 7'd68;
    localparam logic [6:0] VSYNC_END   = 7'd70;

    localparam logic [7:0] GRAY_OFF       = 8'hFF;
    localparam logic [7:0] GRAY_ON        = 8'h00;
    localparam logic [7:0] GRAY_BLANK     = 8'hFF;
    localparam logic [7:0] GRAY_SHADE_OFF = 8'hE0;

    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_CAPT} fetch_state_t;

    // On-dot level darkens by 3 steps per contrast unit, starting from the off level.
    function automatic logic [7:0] shade_on(input logic [5:0] contrast);
        return 8'(10'h0E0 - 10'(contrast) * 10'd3);
    endfunction

endpackage

// File: rtl/lcd_scanout_if.sv
// Scanout bus: dot enable and controller read port in, raster video stream out.
// The slave modport is the scanout block; the master side drives it.
interface lcd_scanout_if;

    logic       pix_ce;
    logic [5:0] lcd_contrast;
    logic [7:0] read_column;
    logic [7:0] read_x;
    logic [3:0] read_y;
    logic [7:0] pixel_out;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       frame_start;
    logic       underrun;

    modport master (
        output pix_ce, lcd_contrast, read_column,
        input  read_x, read_y, pixel_out, hsync, vsync, hblank, vblank, frame_start, underrun
    );

    modport slave (
        input  pix_ce, lcd_contrast, read_column,
        output read_x, read_y, pixel_out, hsync, vsync, hblank, vblank, frame_start, underrun
    );

endinterface

// File: rtl/lcd_timing_gen.sv
// Dot/line counters for the 128x80 raster, next-dot coordinates and sync/blank decode
// of the dot currently being output.
module lcd_timing_gen
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_pix_ce,
    output logic [2:0] o_line,
    output logic [6:0] o_next_x,
    output logic [2:0] o_next_page,
    output logic       o_next_blank,
    output logic       o_hblank,
    output logic       o_vblank,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_dot
);

    logic [6:0] r_h;
    logic [6:0] r_v;
    logic [6:0] w_next_h;
    logic [6:0] w_next_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (i_pix_ce) begin
            r_h <= w_next_h;
            r_v <= w_next_v;
        end
    end

    always_comb begin
        w_next_h = r_h + 7'd1;
        w_next_v = r_v;
        if (r_h == H_LAST) begin
            w_next_h = '0;
            w_next_v = (r_v == V_LAST) ? 7'd0 : r_v + 7'd1;
        end
    end

    assign o_line       = r_v[2:0];
    assign o_next_x     = w_next_h;
    assign o_next_page  = w_next_v[5:3];
    assign o_next_blank = (w_next_h >= H_ACTIVE) || (w_next_v >= V_ACTIVE);
    assign o_hblank     = (r_h >= H_ACTIVE);
    assign o_vblank     = (r_v >= V_ACTIVE);
    assign o_hsync      = (r_h >= HSYNC_START) && (r_h < HSYNC_END);
    assign o_vsync      = (r_v >= VSYNC_START) && (r_v < VSYNC_END);
    assign o_frame_dot  = (r_h == 7'd0) && (r_v == 7'd0);

endmodule

// File: rtl/lcd_scanout.sv
// Walks the 96x64 LCD RAM via the controller read port and emits an 8-bit gray raster.
// Build option LCD_CONTRAST_EN: on-dots shaded from lcd_contrast, sampled at frame start.
module lcd_scanout
    import lcd_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    lcd_scanout_if.slave bus
);

    logic [2:0] w_line;
    logic [6:0] w_next_x;
    logic [2:0] w_next_page;
    logic       w_next_blank;
    logic       w_hblank;
    logic       w_vblank;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_frame_dot;
    logic [7:0] w_gray_on;
    logic [7:0] w_gray_off;

    fetch_state_t r_state;
    logic [7:0]   r_fetch_byte;
    logic [7:0]   r_read_x;
    logic [3:0]   r_read_y;
    logic [7:0]   r_pixel;
    logic         r_hsync;
    logic         r_vsync;
    logic         r_hblank;
    logic         r_vblank;
    logic         r_frame_start;
    logic         r_underrun;

    lcd_timing_gen u_timing (
        .clk          (clk),
        .reset        (reset),
        .i_pix_ce     (bus.pix_ce),
        .o_line       (w_line),
        .o_next_x     (w_next_x),
        .o_next_page  (w_next_page),
        .o_next_blank (w_next_blank),
        .o_hblank     (w_hblank),
        .o_vblank     (w_vblank),
        .o_hsync      (w_hsync),
        .o_vsync      (w_vsync),
        .o_frame_dot  (w_frame_dot)
    );

`ifdef LCD_CONTRAST_EN
    logic [5:0] r_contrast;
    logic [5:0] w_contrast;

    // The frame's first dot already uses the contrast being sampled with it.
    assign w_contrast = w_frame_dot ? bus.lcd_contrast : r_contrast;
    assign w_gray_on  = shade_on(w_contrast);
    assign w_gray_off = GRAY_SHADE_OFF;
`else
    logic w_unused_contrast;

    assign w_unused_contrast = ^bus.lcd_contrast;
    assign w_gray_on         = GRAY_ON;
    assign w_gray_off        = GRAY_OFF;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= F_IDLE;
            r_fetch_byte  <= 8'h00;
            r_read_x      <= 8'd0;
            r_read_y      <= 4'd0;
            r_pixel       <= GRAY_BLANK;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
`ifdef LCD_CONTRAST_EN
            r_contrast    <= 6'd0;
`endif
        end else begin
            r_frame_start <= 1'b0;
            if (bus.pix_ce) begin
                // A dot arriving mid-fetch shows the stale byte and restarts the fetch.
                if (r_state != F_IDLE) r_underrun <= 1'b1;
                r_state       <= F_WAIT;
                r_hblank      <= w_hblank;
                r_vblank      <= w_vblank;
                r_hsync       <= w_hsync;
                r_vsync       <= w_vsync;
                r_frame_start <= w_frame_dot;
                if (w_hblank || w_vblank) r_pixel <= GRAY_BLANK;
                else r_pixel <= r_fetch_byte[w_line] ? w_gray_on : w_gray_off;
                r_read_x <= w_next_blank ? 8'd0 : {1'b0, w_next_x};
                r_read_y <= w_next_blank ? 4'd0 : {1'b0, w_next_page};
`ifdef LCD_CONTRAST_EN
                if (w_frame_dot) r_contrast <= bus.lcd_contrast;
`endif
            end else begin
                unique case (r_state)
                    F_WAIT: r_state <= F_CAPT;
                    F_CAPT: begin
                        r_fetch_byte <= bus.read_column;
                        r_state      <= F_IDLE;
                    end
                    default: r_state <= F_IDLE;
                endcase
            end
        end
    end

    assign bus.read_x      = r_read_x;
    assign bus.read_y      = r_read_y;
    assign bus.pixel_out   = r_pixel;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.hblank      = r_hblank;
    assign bus.vblank      = r_vblank;
    assign bus.frame_start = r_frame_start;
    assign bus.underrun    = r_underrun;

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout: raster timing, fetch addressing, underrun and reset behaviour.
// Define LCD_CONTRAST_EN for both bench and RTL to exercise the contrast build.
module tb_lcd_scanout;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic fs_en = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    int   fs_cnt  = 0;

    int          h, v, nh, nv;
    logic        blank, nblank;
    logic [7:0]  b, pix, on_lvl, off_lvl, ex;
    logic [3:0]  ey;
    logic [31:0] exp_v;
`ifdef LCD_CONTRAST_EN
    logic [5:0]  m_con = 6'd0;
    localparam logic [7:0] ON_A = 8'h80;
    localparam logic [7:0] ON_B = 8'h23;
    localparam logic [7:0] OFF_L = 8'hE0;
`else
    localparam logic [7:0] ON_A = 8'h00;
    localparam logic [7:0] ON_B = 8'h00;
    localparam logic [7:0] OFF_L = 8'hFF;
`endif

    lcd_scanout_if bus ();

    lcd_scanout dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int x, input int page);
        if (x == 0 && page == 0) return 8'h01;
        return 8'((x * 5 + page * 37) & 255);
    endfunction

    // Controller model: one register stage between address and data.
    always @(posedge clk) bus.read_column <= pat(int'(bus.read_x), int'(bus.read_y));

    always @(negedge clk) if (fs_en && bus.frame_start) fs_cnt <= fs_cnt + 1;

    function automatic logic [31:0] dot_vec(input logic [7:0] rx, input logic [3:0] ry,
                                            input logic hb, input logic vb, input logic hs,
                                            input logic vs, input logic fs, input logic ur,
                                            input logic [7:0] px);
        return {6'b0, rx, ry, hb, vb, hs, vs, fs, ur, px};
    endfunction

    function automatic logic [31:0] obs_vec();
        return dot_vec(bus.read_x, bus.read_y, bus.hblank, bus.vblank, bus.hsync, bus.vsync,
                       bus.frame_start, bus.underrun, bus.pixel_out);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic pix_pulse();
        bus.pix_ce = 1'b1;
        @(negedge clk);
        bus.pix_ce = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.pix_ce = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.pix_ce       = 1'b0;
        bus.lcd_contrast = 6'h20;
        reset            = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_state", obs_vec(), dot_vec(8'd0, 4'd0, 1, 1, 0, 0, 0, 0, 8'hFF));
        reset = 1'b0;

        // Full frame plus a few dots of the next, one pix_ce every 4 clk.
        fs_en = 1'b1;
        for (int i = 0; i < 10243; i++) begin
            h = i % 128;
            v = (i / 128) % 80;
            if (i == 5000) bus.lcd_contrast = 6'h3F;
`ifdef LCD_CONTRAST_EN
            if (h == 0 && v == 0) m_con = bus.lcd_contrast;
            on_lvl  = 8'(224 - 3 * int'(m_con));
            off_lvl = 8'hE0;
`else
            on_lvl  = 8'h00;
            off_lvl = 8'hFF;
`endif
            pix_pulse();
            blank  = (h >= 96) || (v >= 64);
            b      = (i == 0) ? 8'h00 : pat(h, v / 8);
            pix    = blank ? 8'hFF : (b[v % 8] ? on_lvl : off_lvl);
            nh     = (h + 1) % 128;
            nv     = (h == 127) ? (v + 1) % 80 : v;
            nblank = (nh >= 96) || (nv >= 64);
            ex     = nblank ? 8'd0 : 8'(nh);
            ey     = nblank ? 4'd0 : 4'(nv / 8);
            exp_v  = dot_vec(ex, ey, h >= 96, v >= 64, (h >= 104) && (h < 112),
                             (v >= 68) && (v < 70), (h == 0) && (v == 0), 1'b0, pix);
            check_eq("dot", obs_vec(), exp_v);
            if (i == 0) check_eq("fs_first", 32'(bus.frame_start), 32'd1);
            if (i == 1) check_eq("pix_1_0_on", 32'(bus.pixel_out), 32'(ON_A));
            if (i == 128) check_eq("pix_0_1_off", 32'(bus.pixel_out), 32'(OFF_L));
            if (i == 991) check_eq("addr_95_7", {bus.read_x, bus.read_y}, 32'h000);
            if (i == 1930) check_eq("addr_10_15", {bus.read_x, bus.read_y}, {8'd11, 4'd1});
            if (i == 5001) check_eq("pix_contrast_held", 32'(bus.pixel_out), 32'(ON_A));
            if (i == 10240) check_eq("pix_0_0_frame2", 32'(bus.pixel_out), 32'(ON_B));
            @(negedge clk);
            if (i == 0) check_eq("fs_pulse_end", 32'(bus.frame_start), 32'd0);
            repeat (2) @(negedge clk);
        end
        fs_en = 1'b0;
        check_eq("fs_per_frame", 32'(fs_cnt), 32'd2);
        check_eq("underrun_gap4", 32'(bus.underrun), 32'd0);

        do_reset();
        for (int k = 0; k < 40; k++) begin
            pix_pulse();
            repeat (2) @(negedge clk);
        end
        check_eq("underrun_gap3", 32'(bus.underrun), 32'd0);
        for (int k = 0; k < 4; k++) begin
            pix_pulse();
            @(negedge clk);
        end
        check_eq("underrun_gap2", 32'(bus.underrun), 32'd1);
        for (int k = 0; k < 10; k++) begin
            pix_pulse();
            repeat (3) @(negedge clk);
        end
        check_eq("underrun_sticky", 32'(bus.underrun), 32'd1);
        do_reset();
        check_eq("underrun_reset", 32'(bus.underrun), 32'd0);

        // Run up to dot (50,30), then reset together with its pix_ce.
        for (int k = 0; k < 3890; k++) begin
            pix_pulse();
            repeat (2) @(negedge clk);
        end
        check_eq("pre_reset_addr", {bus.read_x, bus.read_y, bus.hblank, bus.vblank},
                 {8'd50, 4'd3, 2'b00});
        reset      = 1'b1;
        bus.pix_ce = 1'b1;
        @(negedge clk);
        check_eq("reset_mid", obs_vec(), dot_vec(8'd0, 4'd0, 1, 1, 0, 0, 0, 0, 8'hFF));
        reset      = 1'b0;
        bus.pix_ce = 1'b0;
        repeat (2) @(negedge clk);
        pix_pulse();
        check_eq("restart_dot", {bus.frame_start, bus.read_x, bus.read_y}, {1'b1, 8'd1, 4'd0});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
